// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: captures WIDTH serial bits per frame and hands
// completed words to a valid/ready holding register. Optional even parity via SIPO_PARITY_EN.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       sin_valid,
    input  logic                       sin,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH+1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic perr_next;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next, shifted, word;
    logic [CW-1:0]    cnt_next;
    logic             complete;

    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], sin} : {sin, shift_reg[WIDTH-1:1]};
    assign busy    = (state != IDLE);

    // frame_start always wins, so a restart on the completing cycle discards the word
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        complete   = 1'b0;
        word       = shifted;
`ifdef SIPO_PARITY_EN
        perr_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = SHIFT;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    shift_next = '0;
                    cnt_next   = '0;
                end else if (sin_valid) begin
                    shift_next = shifted;
                    if (bit_cnt == CW'(WIDTH-1)) begin
`ifdef SIPO_PARITY_EN
                        state_next = PAR;
                        cnt_next   = CW'(WIDTH);
`else
                        state_next = IDLE;
                        cnt_next   = '0;
                        complete   = 1'b1;
`endif
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                word = shift_reg;
                if (frame_start) begin
                    state_next = SHIFT;
                    shift_next = '0;
                    cnt_next   = '0;
                end else if (sin_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (^{shift_reg, sin}) begin
                        perr_next = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Holding register accepts a new word when empty or being drained this same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= cnt_next;
            if (complete && (!dout_valid || dout_ready)) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else begin
                if (complete) begin
                    overrun <= 1'b1;
                end
                if (dout_valid && dout_ready) begin
                    dout_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame controller for the serial-in/parallel-out path. It sequences bit capture from a serial stream into a WIDTH-bit shift register and counts bits per frame. Completed words go to a holding register with a valid/ready handshake to the parallel consumer. Sits between a serial source (sensor, link pin, test stimulus) and any word-oriented block downstream.

## Interface
- WIDTH, 4, data bits per frame (2..32)
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle pulse; arms/restarts frame capture
- sin_valid  in  1  sin carries a valid bit this cycle
- sin  in  1  serial data bit
- dout  out  WIDTH  completed word (holding register)
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout when high with dout_valid
- busy  out  1  frame capture in progress (state != IDLE)
- bit_cnt  out  $clog2(WIDTH+1)  data bits captured in current frame
- overrun  out  1  sticky: a completed word was dropped because holding register was full
- parity_err  out  1  one-cycle pulse: parity mismatch, word dropped (see Configuration)

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with SIPO_PARITY_EN).
- IDLE: sin_valid ignored. frame_start -> SHIFT, bit_cnt=0, shift reg cleared.
- SHIFT: each cycle with sin_valid=1, shift sin in (left shift into bit 0 if MSB_FIRST=1, else right shift into bit WIDTH-1), bit_cnt+1.
- On the cycle the WIDTH-th bit is accepted: without parity, word completes and FSM -> IDLE. With parity, FSM -> PAR.
- PAR: next sin_valid bit is the even-parity bit. XOR of data bits and parity bit = 0 -> word completes; else parity_err pulses, word discarded. FSM -> IDLE either way.
- Word completion: if holding register free, or freed by a handshake in the same cycle, load dout and set dout_valid. Otherwise set overrun and discard the new word; held dout is unchanged.
- frame_start while in SHIFT or PAR: partial frame discarded, bit_cnt=0, stay/return to SHIFT. frame_start on the completing cycle takes priority over completion: the word is discarded.
- frame_start and completion are independent of the output handshake; a new frame may be captured while dout is held.
- dout_valid clears on dout_valid & dout_ready unless a new word loads the same cycle.
- bit_cnt saturates at WIDTH. It returns to 0 on entry to IDLE or on restart.
- overrun clears only on rst.

## Timing
- Reset values: dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0, parity_err=0, state IDLE, shift reg 0.
- rst mid-frame aborts immediately; no partial word is emitted.
- frame_start -> busy=1 on the next cycle. The first bit is accepted no earlier than the cycle after frame_start.
- Last data bit (or parity bit) accepted in cycle N -> dout_valid=1, busy=0 in cycle N+1.
- Back-to-back frames: frame_start may be asserted in cycle N+1; no dead cycles beyond that.
- dout stable while dout_valid=1 and not handshaken.
- parity_err and overrun assert in cycle N+1 alongside the would-be load.

## Configuration
- SIPO_PARITY_EN defined: PAR state and parity check compiled in. Each frame is WIDTH data bits plus 1 even-parity bit.
- Undefined: no PAR state, frames are exactly WIDTH bits, parity_err tied to 0.

## Test plan
- WIDTH=4, MSB_FIRST=1: frame_start, then bits 1,0,1,1 on consecutive cycles -> dout=4'b1011, dout_valid=1 one cycle after last bit; dout_ready=1 -> dout_valid=0 next cycle.
- MSB_FIRST=0, same bits 1,0,1,1 -> dout=4'b1101. Gaps in sin_valid (idle cycles between bits) -> same result, bit_cnt holds during gaps.
- dout_ready=0: two full frames 1111 then 0000 -> dout stays 4'b1111, overrun=1. Then dout_ready=1 on the exact cycle the next word (0101) completes -> dout=4'b0101, dout_valid stays 1, no new overrun.
- Restart/reset: frame_start, bits 1,1, frame_start, bits 0,0,1,0 -> dout=4'b0010. rst after 2 bits of a frame -> all outputs at reset values, no word emitted.
- SIPO_PARITY_EN: bits 1,0,1,1 + parity 1 -> dout=4'b1011 valid. Bits 1,0,1,1 + parity 0 -> parity_err 1-cycle pulse, dout_valid unchanged.
- frame_start on the last-bit cycle -> no word emitted, busy stays 1, bit_cnt=0.
